jpc_ifetch_pf: RTL and testbench

Parametrised prefetching instruction-fetch unit: the next-generation replacement for `jpc_ifetch`. It accepts a start/redirect PC and streams sequential fetch addresses to instruction memory with up to `MAX_OUTSTANDING` requests in flight. In-order responses are buffered in a `DEPTH`-entry instruction queue, and each instruction is delivered downstream with its PC. It sits between the PC/branch logic and decode, with `jpc_32bram` or a cache on its memory side.

---
 rtl/jpc_ifetch_pf_pkg.sv | 19 +
 rtl/jpc_fifo.sv | 61 ++++++
 rtl/jpc_ifetch_pf.sv | 129 ++++++++++++
 tb/tb_jpc_ifetch_pf.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpc_ifetch_pf_pkg.sv
// Shared configuration, state encoding and helpers for the prefetching fetch unit.
package jpc_ifetch_pf_pkg;

  localparam int unsigned JPC_ADDRESS_WIDTH     = 32;
  localparam int unsigned JPC_INSTRUCTION_WIDTH = 32;
  localparam int unsigned JPC_MEMDATA_WIDTH     = 32;
  localparam logic [JPC_ADDRESS_WIDTH-1:0] JPC_NULL_ADDRESS = '0;

  typedef enum logic [0:0] {
    JPC_IFPF_IDLE = 1'b0,
    JPC_IFPF_RUN  = 1'b1
  } ifpf_state_e;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jpc_fifo.sv
// Synchronous FIFO with clear and occupancy count; pop_data shows the head entry.
module jpc_fifo
  import jpc_ifetch_pf_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic [WIDTH-1:0]                pop_data,
  output logic [cnt_width(DEPTH)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push  = push & (count_q != CW'(DEPTH));
  assign do_pop   = pop & (count_q != '0);
  assign pop_data = mem_q[rd_q];
  assign count    = count_q;

  // Storage write; contents are only observed through the count-qualified head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; clear has priority over push/pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jpc_ifetch_pf.sv
// Prefetching instruction-fetch unit: streams sequential fetches, buffers in-order
// responses with their PCs, and drops responses belonging to a redirected stream.
module jpc_ifetch_pf
  import jpc_ifetch_pf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = JPC_ADDRESS_WIDTH,
  parameter int unsigned INSTR_WIDTH     = JPC_INSTRUCTION_WIDTH,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  pc_I,
  input  logic                   pc_valid_I,
  output logic                   pc_ready_O,
  output logic [INSTR_WIDTH-1:0] instr_O,
  output logic [ADDR_WIDTH-1:0]  instr_pc_O,
  output logic                   instr_valid_O,
  input  logic                   instr_ready_I,
  output logic [ADDR_WIDTH-1:0]  mem_addr_O,
  output logic                   mem_addr_valid_O,
  input  logic                   mem_addr_ready_I,
  input  logic [INSTR_WIDTH-1:0] mem_data_I,
  input  logic                   mem_data_valid_I,
  output logic                   mem_data_ready_O
);

  localparam int unsigned QW   = ADDR_WIDTH + INSTR_WIDTH;
  localparam int unsigned QCW  = cnt_width(DEPTH);
  localparam int unsigned OW   = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned STEP = INSTR_WIDTH / 8;

  ifpf_state_e           state_q;
  ifpf_state_e           state_d;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q;
  logic [OW-1:0]         discard_q;
  logic [OW-1:0]         outstanding;
  logic [QCW-1:0]        q_count;
  logic [QW-1:0]         q_head;
  logic [ADDR_WIDTH-1:0] tag_head;
  logic                  issue_ok;

  logic pc_fire;
  logic addr_fire;
  logic data_fire;
  logic instr_fire;
  logic keep_resp;

  assign pc_ready_O       = ~rst;
  assign pc_fire          = pc_valid_I & pc_ready_O;
  assign mem_addr_valid_O = issue_ok;
  assign mem_addr_O       = fetch_ptr_q;
  assign mem_data_ready_O = (outstanding != '0);
  assign addr_fire        = mem_addr_valid_O & mem_addr_ready_I;
  assign data_fire        = mem_data_valid_I & mem_data_ready_O;
  assign instr_valid_O    = (q_count != '0);
  assign instr_fire       = instr_valid_O & instr_ready_I;
  assign keep_resp        = data_fire & (discard_q == '0);
  assign instr_O          = instr_valid_O ? q_head[INSTR_WIDTH-1:0] : '0;
  assign instr_pc_O       = instr_valid_O ? q_head[QW-1:INSTR_WIDTH]
                                          : ADDR_WIDTH'(JPC_NULL_ADDRESS);

  // Next state and issue permission; reservation covers in-flight plus buffered entries.
  always_comb begin
    state_d  = state_q;
    issue_ok = 1'b0;
    case (state_q)
      JPC_IFPF_IDLE: issue_ok = 1'b0;
      JPC_IFPF_RUN:  issue_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                                (32'(outstanding) + 32'(q_count) < DEPTH);
    endcase
    if (pc_fire) state_d = JPC_IFPF_RUN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= JPC_IFPF_IDLE;
    else     state_q <= state_d;
  end

  // Fetch pointer: loaded on redirect, otherwise advances (wrapping) on each accepted request.
  always_ff @(posedge clk) begin
    if (rst)            fetch_ptr_q <= ADDR_WIDTH'(JPC_NULL_ADDRESS);
    else if (pc_fire)   fetch_ptr_q <= pc_I;
    else if (addr_fire) fetch_ptr_q <= fetch_ptr_q + ADDR_WIDTH'(STEP);
  end

  // Responses still owed to the old stream after a redirect are counted and dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      discard_q <= '0;
    end else if (pc_fire) begin
      discard_q <= outstanding + OW'(addr_fire) - OW'(data_fire);
    end else if (data_fire && (discard_q != '0)) begin
      discard_q <= discard_q - OW'(1);
    end
  end

  // PC tags of accepted requests; its occupancy is the outstanding-request count.
  jpc_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .push      (addr_fire),
    .push_data (fetch_ptr_q),
    .pop       (data_fire),
    .pop_data  (tag_head),
    .count     (outstanding)
  );

  // Instruction queue of {pc, instruction}; flushed by any redirect.
  jpc_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (pc_fire),
    .push      (keep_resp),
    .push_data ({tag_head, mem_data_I}),
    .pop       (instr_fire),
    .pop_data  (q_head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_jpc_ifetch_pf.sv
// Randomised scoreboard bench for jpc_ifetch_pf with an in-order memory responder.
module tb_jpc_ifetch_pf;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_I = '0;
  logic          pc_valid_I = 1'b0;
  logic          pc_ready_O;
  logic [IW-1:0] instr_O;
  logic [AW-1:0] instr_pc_O;
  logic          instr_valid_O;
  logic          instr_ready_I = 1'b0;
  logic [AW-1:0] mem_addr_O;
  logic          mem_addr_valid_O;
  logic          mem_addr_ready_I = 1'b1;
  logic [IW-1:0] mem_data_I = '0;
  logic          mem_data_valid_I = 1'b0;
  logic          mem_data_ready_O;

  always #5 clk = ~clk;

  jpc_ifetch_pf #(
    .ADDR_WIDTH      (AW),
    .INSTR_WIDTH     (IW),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_I             (pc_I),
    .pc_valid_I       (pc_valid_I),
    .pc_ready_O       (pc_ready_O),
    .instr_O          (instr_O),
    .instr_pc_O       (instr_pc_O),
    .instr_valid_O    (instr_valid_O),
    .instr_ready_I    (instr_ready_I),
    .mem_addr_O       (mem_addr_O),
    .mem_addr_valid_O (mem_addr_valid_O),
    .mem_addr_ready_I (mem_addr_ready_I),
    .mem_data_I       (mem_data_I),
    .mem_data_valid_I (mem_data_valid_I),
    .mem_data_ready_O (mem_data_ready_O)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: expected delivery stream, expected next fetch address, pending memory requests.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_tail = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] pend[$];
  bit            active = 1'b0;
  bit            mem_hold = 1'b0;
  bit            mem_rand = 1'b0;
  bit            prev_hold = 1'b0;
  logic [IW-1:0] prev_instr = '0;
  logic [AW-1:0] prev_pc = '0;
  int            addr_fires = 0;
  int            instr_fires = 0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers accepted requests in order, one cycle after acceptance at the earliest.
  always @(negedge clk) begin
    if (pend.size() > 0 && !mem_hold && (!mem_rand || $urandom_range(0, 2) != 0)) begin
      mem_data_valid_I = 1'b1;
      mem_data_I       = mem_word(pend[0]);
    end else begin
      mem_data_valid_I = 1'b0;
      mem_data_I       = $urandom;
    end
  end

  // Monitor: works out which handshakes fire at the coming edge and scores them.
  always @(negedge clk) begin
    bit pc_f, a_f, d_f, i_f;
    logic [AW-1:0] e;
    #2;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      active    = 1'b0;
      prev_hold = 1'b0;
    end else begin
      pc_f = pc_valid_I && pc_ready_O;
      a_f  = mem_addr_valid_O && mem_addr_ready_I;
      d_f  = mem_data_valid_I && mem_data_ready_O;
      i_f  = instr_valid_O && instr_ready_I;
      if (mem_data_valid_I) check("data_ready", 64'(mem_data_ready_O), 64'(1));
      if (!active) check("idle_no_issue", 64'(mem_addr_valid_O), 64'(0));
      if (prev_hold) begin
        check("hold_valid", 64'(instr_valid_O), 64'(1));
        check("hold_instr", 64'(instr_O), 64'(prev_instr));
        check("hold_pc", 64'(instr_pc_O), 64'(prev_pc));
      end
      if (a_f) begin
        check("fetch_addr", 64'(mem_addr_O), 64'(exp_addr));
        exp_addr = exp_addr + 32'd4;
        pend.push_back(mem_addr_O);
        addr_fires++;
      end
      if (d_f && pend.size() > 0) void'(pend.pop_front());
      if (i_f && !pc_f) begin
        instr_fires++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL instr_unexpected: got pc %h data %h, expected no instruction", instr_pc_O, instr_O);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 64'(instr_pc_O), 64'(e));
          check("instr_data", 64'(instr_O), 64'(mem_word(e)));
          exp_q.push_back(exp_tail);
          exp_tail = exp_tail + 32'd4;
        end
      end
      prev_hold  = instr_valid_O && !instr_ready_I && !pc_f;
      prev_instr = instr_O;
      prev_pc    = instr_pc_O;
      if (pc_f) begin
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(pc_I + 32'(4 * k));
        exp_tail = pc_I + 32'd32;
        exp_addr = pc_I;
        active   = 1'b1;
      end
    end
  end

  task automatic redirect(input logic [AW-1:0] pc);
    @(negedge clk);
    pc_valid_I = 1'b1;
    pc_I       = pc;
    @(negedge clk);
    pc_valid_I = 1'b0;
  endtask

  initial begin
    int base;
    int waited;
    bit seen;

    repeat (3) @(negedge clk);
    #3 check("pc_ready_in_rst", 64'(pc_ready_O), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_pc_ready", 64'(pc_ready_O), 64'(1));
    check("rst_instr_valid", 64'(instr_valid_O), 64'(0));
    check("rst_addr_valid", 64'(mem_addr_valid_O), 64'(0));
    check("rst_data_ready", 64'(mem_data_ready_O), 64'(0));
    check("rst_mem_addr", 64'(mem_addr_O), 64'(0));
    check("rst_instr", 64'(instr_O), 64'(0));
    check("rst_instr_pc", 64'(instr_pc_O), 64'(0));

    // First fetch from 0 and its latency.
    instr_ready_I = 1'b1;
    @(negedge clk);
    pc_valid_I = 1'b1;
    pc_I       = 32'h0;
    @(negedge clk);
    pc_valid_I = 1'b0;
    #3;
    check("issue_valid_n1", 64'(mem_addr_valid_O), 64'(1));
    check("issue_addr_n1", 64'(mem_addr_O), 64'(0));
    waited = 1;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      if (instr_valid_O) seen = 1'b1;
      else begin
        @(negedge clk);
        #3;
        waited++;
      end
    end
    check("first_latency", 64'(waited), 64'(3));
    check("first_instr", 64'(instr_O), 64'(32'hDEAD_BEEF));
    check("first_pc", 64'(instr_pc_O), 64'(0));

    // Stalled consumer: exactly DEPTH fetches, head held stable.
    @(negedge clk);
    instr_ready_I = 1'b0;
    pc_valid_I    = 1'b1;
    pc_I          = 32'h0;
    #3 base = addr_fires;
    @(negedge clk);
    pc_valid_I = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    check("stall_fetch_count", 64'(addr_fires - base), 64'(4));
    check("stall_addr_valid", 64'(mem_addr_valid_O), 64'(0));
    check("stall_instr", 64'(instr_O), 64'(32'hDEAD_BEEF));
    check("stall_pc", 64'(instr_pc_O), 64'(0));
    base = instr_fires;
    @(negedge clk);
    instr_ready_I = 1'b1;
    repeat (20) @(negedge clk);
    #3 check("stall_release_streams", 64'(instr_fires - base >= 8), 64'(1));

    // Redirect with two requests held at memory.
    @(negedge clk);
    mem_hold   = 1'b1;
    pc_valid_I = 1'b1;
    pc_I       = 32'h0;
    @(negedge clk);
    pc_valid_I = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("held_data_ready", 64'(mem_data_ready_O), 64'(1));
    check("held_addr_valid", 64'(mem_addr_valid_O), 64'(0));
    @(negedge clk);
    mem_hold = 1'b0;
    pc_valid_I = 1'b1;
    pc_I       = 32'h40;
    @(negedge clk);
    pc_valid_I = 1'b0;
    waited = 0;
    #3;
    while (!instr_valid_O && waited < 20) begin
      @(negedge clk);
      #3;
      waited++;
    end
    check("redirect_first_pc", 64'(instr_pc_O), 64'(32'h40));

    // Address wrap at the top of the space.
    base = instr_fires;
    redirect(32'hFFFF_FFFC);
    repeat (15) @(negedge clk);
    #3 check("wrap_streams", 64'(instr_fires - base >= 4), 64'(1));

    // Reset mid-stream.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("mid_rst_instr_valid", 64'(instr_valid_O), 64'(0));
    check("mid_rst_addr_valid", 64'(mem_addr_valid_O), 64'(0));
    check("mid_rst_data_ready", 64'(mem_data_ready_O), 64'(0));
    check("mid_rst_mem_addr", 64'(mem_addr_O), 64'(0));
    check("mid_rst_instr", 64'(instr_O), 64'(0));
    base = instr_fires;
    repeat (8) @(negedge clk);
    #3 check("mid_rst_silent", 64'(instr_fires - base), 64'(0));

    // Random traffic, redirects and occasional resets.
    mem_rand = 1'b1;
    redirect(32'h100);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rst              = ($urandom_range(0, 499) == 0);
      pc_valid_I       = ($urandom_range(0, 29) == 0);
      pc_I             = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                                     : {$urandom, 2'b00} & 32'h0000_FFFC;
      instr_ready_I    = ($urandom_range(0, 3) != 0);
      mem_addr_ready_I = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    rst        = 1'b0;
    pc_valid_I = 1'b0;
    instr_ready_I = 1'b1;
    mem_addr_ready_I = 1'b1;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
